// File: rtl/cpu31_pkg.sv
// ============================================================================
// Module : cpu31_pkg
// Brief  : Opcode/funct encodings and control enums for the CPU31 core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu31_pkg;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_addiu = 6'h09;
  localparam logic [5:0] c_op_slti  = 6'h0a;
  localparam logic [5:0] c_op_sltiu = 6'h0b;
  localparam logic [5:0] c_op_andi  = 6'h0c;
  localparam logic [5:0] c_op_ori   = 6'h0d;
  localparam logic [5:0] c_op_xori  = 6'h0e;
  localparam logic [5:0] c_op_lui   = 6'h0f;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2b;

  localparam logic [5:0] c_fn_sll   = 6'h00;
  localparam logic [5:0] c_fn_srl   = 6'h02;
  localparam logic [5:0] c_fn_sra   = 6'h03;
  localparam logic [5:0] c_fn_sllv  = 6'h04;
  localparam logic [5:0] c_fn_srlv  = 6'h06;
  localparam logic [5:0] c_fn_srav  = 6'h07;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_addu  = 6'h21;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_subu  = 6'h23;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_xor   = 6'h26;
  localparam logic [5:0] c_fn_nor   = 6'h27;
  localparam logic [5:0] c_fn_slt   = 6'h2a;
  localparam logic [5:0] c_fn_sltu  = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    NPC_PC4, NPC_BR, NPC_J, NPC_JR
  } npc_sel_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu31_regfile.sv
// ============================================================================
// Module : cpu31_regfile
// Brief  : 32x32 GPR file, two async read ports, one sync write, $0 tied low.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu31_regfile
  import cpu31_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2
);

  logic [31:0] r_regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/sccomp_dataflow.sv
// ============================================================================
// Module : sccomp_dataflow
// Brief  : Single-cycle MIPS-32 core (31 instr) with inline IMEM/DMEM.
//          Define OVERFLOW_TRAP_EN to suppress writeback on add/addi/sub overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sccomp_dataflow
  import cpu31_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = 32'h0040_0000,
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter string       IMEM_FILE  = "imem.hex"
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  // Depths are powers of two so the modulo wrap is a plain bit slice.
  localparam int c_iaw = $clog2(IMEM_DEPTH);
  localparam int c_daw = $clog2(DMEM_DEPTH);

  logic [31:0] r_pc;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_dmem [DMEM_DEPTH];

  logic [31:0] w_ioff;
  assign w_ioff = r_pc - PC_RESET;
  assign inst   = r_imem[w_ioff[c_iaw+1:2]];
  assign pc     = r_pc;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
  logic [25:0] w_jidx;
  assign {w_op, w_rs, w_rt, w_rd, w_shamt, w_funct} = inst;
  assign w_imm  = inst[15:0];
  assign w_jidx = inst[25:0];

  logic [31:0] w_rs_val, w_rt_val, w_wb_data;
  logic        w_rf_we;
  logic [4:0]  w_dst;

  cpu31_regfile u_regfile (
    .clk      (clk_in),
    .rst_n    (reset),
    .i_we     (w_rf_we),
    .i_waddr  (w_dst),
    .i_wdata  (w_wb_data),
    .i_raddr1 (w_rs),
    .o_rdata1 (w_rs_val),
    .i_raddr2 (w_rt),
    .o_rdata2 (w_rt_val)
  );

  alu_op_e  w_alu_op;
  npc_sel_e w_npc_sel;
  logic     w_use_imm, w_zext, w_shift_var, w_we, w_mem_we, w_mem_rd, w_link, w_ovf_chk;

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_npc_sel   = NPC_PC4;
    w_use_imm   = 1'b0;
    w_zext      = 1'b0;
    w_shift_var = 1'b0;
    w_we        = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_rd    = 1'b0;
    w_link      = 1'b0;
    w_ovf_chk   = 1'b0;
    w_dst       = w_rt;
    case (w_op)
      c_op_rtype: begin
        w_we  = 1'b1;
        w_dst = w_rd;
        case (w_funct)
          c_fn_add:  begin w_alu_op = ALU_ADD; w_ovf_chk = 1'b1; end
          c_fn_addu: w_alu_op = ALU_ADD;
          c_fn_sub:  begin w_alu_op = ALU_SUB; w_ovf_chk = 1'b1; end
          c_fn_subu: w_alu_op = ALU_SUB;
          c_fn_and:  w_alu_op = ALU_AND;
          c_fn_or:   w_alu_op = ALU_OR;
          c_fn_xor:  w_alu_op = ALU_XOR;
          c_fn_nor:  w_alu_op = ALU_NOR;
          c_fn_slt:  w_alu_op = ALU_SLT;
          c_fn_sltu: w_alu_op = ALU_SLTU;
          c_fn_sll:  w_alu_op = ALU_SLL;
          c_fn_srl:  w_alu_op = ALU_SRL;
          c_fn_sra:  w_alu_op = ALU_SRA;
          c_fn_sllv: begin w_alu_op = ALU_SLL; w_shift_var = 1'b1; end
          c_fn_srlv: begin w_alu_op = ALU_SRL; w_shift_var = 1'b1; end
          c_fn_srav: begin w_alu_op = ALU_SRA; w_shift_var = 1'b1; end
          c_fn_jr:   begin w_we = 1'b0; w_npc_sel = NPC_JR; end
          default:   w_we = 1'b0;
        endcase
      end
      c_op_addi:  begin w_we = 1'b1; w_use_imm = 1'b1; w_ovf_chk = 1'b1; end
      c_op_addiu: begin w_we = 1'b1; w_use_imm = 1'b1; end
      c_op_slti:  begin w_we = 1'b1; w_use_imm = 1'b1; w_alu_op = ALU_SLT; end
      c_op_sltiu: begin w_we = 1'b1; w_use_imm = 1'b1; w_alu_op = ALU_SLTU; end
      c_op_andi:  begin w_we = 1'b1; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_AND; end
      c_op_ori:   begin w_we = 1'b1; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_OR; end
      c_op_xori:  begin w_we = 1'b1; w_use_imm = 1'b1; w_zext = 1'b1; w_alu_op = ALU_XOR; end
      c_op_lui:   begin w_we = 1'b1; w_alu_op = ALU_LUI; end
      c_op_lw:    begin w_we = 1'b1; w_use_imm = 1'b1; w_mem_rd = 1'b1; end
      c_op_sw:    begin w_use_imm = 1'b1; w_mem_we = 1'b1; end
      c_op_beq:   if (w_rs_val == w_rt_val) w_npc_sel = NPC_BR;
      c_op_bne:   if (w_rs_val != w_rt_val) w_npc_sel = NPC_BR;
      c_op_j:     w_npc_sel = NPC_J;
      c_op_jal:   begin w_npc_sel = NPC_J; w_we = 1'b1; w_dst = 5'd31; w_link = 1'b1; end
      default:    ;
    endcase
  end

  logic [31:0] w_imm_ext, w_b, w_alu_res;
  logic [4:0]  w_sa;
  logic        w_ovf;

  assign w_imm_ext = w_zext ? {16'h0, w_imm} : sext16(w_imm);
  assign w_b       = w_use_imm ? w_imm_ext : w_rt_val;
  assign w_sa      = w_shift_var ? w_rs_val[4:0] : w_shamt;

  always_comb begin
    w_alu_res = '0;
    w_ovf     = 1'b0;
    case (w_alu_op)
      ALU_ADD: begin
        w_alu_res = w_rs_val + w_b;
        w_ovf     = (w_rs_val[31] == w_b[31]) && (w_alu_res[31] != w_rs_val[31]);
      end
      ALU_SUB: begin
        w_alu_res = w_rs_val - w_b;
        w_ovf     = (w_rs_val[31] != w_b[31]) && (w_alu_res[31] != w_rs_val[31]);
      end
      ALU_AND:  w_alu_res = w_rs_val & w_b;
      ALU_OR:   w_alu_res = w_rs_val | w_b;
      ALU_XOR:  w_alu_res = w_rs_val ^ w_b;
      ALU_NOR:  w_alu_res = ~(w_rs_val | w_b);
      ALU_SLT:  w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_b)};
      ALU_SLTU: w_alu_res = {31'd0, w_rs_val < w_b};
      ALU_SLL:  w_alu_res = w_b << w_sa;
      ALU_SRL:  w_alu_res = w_b >> w_sa;
      ALU_SRA:  w_alu_res = $signed(w_b) >>> w_sa;
      ALU_LUI:  w_alu_res = {w_imm, 16'h0};
      default:  w_alu_res = '0;
    endcase
  end

  logic [31:0] w_doff, w_dmem_rdata, w_pc4, w_npc;
  assign w_doff       = w_alu_res - DMEM_BASE;
  assign w_dmem_rdata = r_dmem[w_doff[c_daw+1:2]];

  // DMEM has no reset: stored data survives a CPU reset.
  always_ff @(posedge clk_in) begin
    if (w_mem_we) r_dmem[w_doff[c_daw+1:2]] <= w_rt_val;
  end

  assign w_pc4     = r_pc + 32'd4;
  assign w_wb_data = w_link ? w_pc4 : (w_mem_rd ? w_dmem_rdata : w_alu_res);

`ifdef OVERFLOW_TRAP_EN
  assign w_rf_we = w_we && !(w_ovf_chk && w_ovf);
`else
  assign w_rf_we = w_we;
  logic w_unused_ovf;
  assign w_unused_ovf = ^{w_ovf, w_ovf_chk};
`endif

  always_comb begin
    w_npc = w_pc4;
    case (w_npc_sel)
      NPC_BR:  w_npc = w_pc4 + (w_imm_ext << 2);
      NPC_J:   w_npc = {w_pc4[31:28], w_jidx, 2'b00};
      NPC_JR:  w_npc = w_rs_val;
      default: w_npc = w_pc4;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_pc <= PC_RESET;
    else        r_pc <= w_npc;
  end

  logic w_unused_addr;
  assign w_unused_addr = ^{w_ioff[31:c_iaw+2], w_ioff[1:0], w_doff[31:c_daw+2], w_doff[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_sccomp_dataflow.sv
// ============================================================================
// Module : tb_sccomp_dataflow
// Brief  : Scoreboard bench for sccomp_dataflow against an ISA-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sccomp_dataflow;

  localparam logic [31:0] PC0   = 32'h0040_0000;
  localparam logic [31:0] DBASE = 32'h1001_0000;
  localparam logic [5:0] FNS [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                      6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  localparam logic [5:0] IOPS [8] = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst, pc;

  sccomp_dataflow #(.IMEM_FILE("")) dut (
    .clk_in (clk),
    .reset  (reset),
    .inst   (inst),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;
  logic [31:0] prog_mem [1024];

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [31:0][31:0] regs;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iidx(input logic [31:0] a);
    return int'(((a - PC0) >> 2) % 32'd1024);
  endfunction

  function automatic int didx(input logic [31:0] a);
    return int'(((a - DBASE) >> 2) % 32'd1024);
  endfunction

  function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jt_i(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // ISA reference: executes one instruction on the model state.
  task automatic model_step();
    logic [31:0] w, a, b, res, si, zi, pc4, npc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    bit          wr, chk, ovf;
    longint      s;
    w  = m_imem[iidx(m_pc)];
    op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; sh = w[10:6]; fn = w[5:0];
    a  = m_reg[rs]; b = m_reg[rt];
    si = {{16{w[15]}}, w[15:0]};
    zi = {16'h0, w[15:0]};
    pc4 = m_pc + 32'd4; npc = pc4;
    wr = 0; chk = 0; res = '0; dst = rt; s = 0;
    case (op)
      6'h00: begin
        dst = rd; wr = 1;
        case (fn)
          6'h20: begin res = a + b; s = longint'($signed(a)) + longint'($signed(b)); chk = 1; end
          6'h21: res = a + b;
          6'h22: begin res = a - b; s = longint'($signed(a)) - longint'($signed(b)); chk = 1; end
          6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2b: res = (a < b) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          6'h03: res = $signed(b) >>> sh;
          6'h04: res = b << a[4:0];
          6'h06: res = b >> a[4:0];
          6'h07: res = $signed(b) >>> a[4:0];
          6'h08: begin wr = 0; npc = a; end
          default: wr = 0;
        endcase
      end
      6'h08: begin wr = 1; res = a + si; s = longint'($signed(a)) + longint'($signed(si)); chk = 1; end
      6'h09: begin wr = 1; res = a + si; end
      6'h0a: begin wr = 1; res = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0; end
      6'h0b: begin wr = 1; res = (a < si) ? 32'd1 : 32'd0; end
      6'h0c: begin wr = 1; res = a & zi; end
      6'h0d: begin wr = 1; res = a | zi; end
      6'h0e: begin wr = 1; res = a ^ zi; end
      6'h0f: begin wr = 1; res = {w[15:0], 16'h0}; end
      6'h23: begin wr = 1; res = m_dmem[didx(a + si)]; end
      6'h2b: m_dmem[didx(a + si)] = b;
      6'h04: if (a == b) npc = pc4 + (si << 2);
      6'h05: if (a != b) npc = pc4 + (si << 2);
      6'h02: npc = {pc4[31:28], w[25:0], 2'b00};
      6'h03: begin npc = {pc4[31:28], w[25:0], 2'b00}; wr = 1; dst = 5'd31; res = pc4; end
      default: ;
    endcase
    // Overflow: true sum differs from the wrapped 32-bit result.
    ovf = chk && (s != longint'($signed(res)));
`ifdef OVERFLOW_TRAP_EN
    if (ovf) wr = 0;
`endif
    if (wr && dst != 5'd0) m_reg[dst] = res;
    m_pc = npc;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc   = m_pc;
    e.inst = m_imem[iidx(m_pc)];
    for (int r = 0; r < 32; r++) e.regs[r] = m_reg[r];
    exp_q.push_back(e);
  endtask

  always begin : p_monitor
    exp_t e;
    int   bad;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("inst", inst, e.inst);
      bad = 0;
      for (int r = 31; r >= 0; r--) if (dut.u_regfile.r_regs[r] !== e.regs[r]) bad = r;
      check("regs", dut.u_regfile.r_regs[bad], e.regs[bad]);
    end
  end

  task automatic start_prog(input int hold_ns);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 1024; k++) begin
      m_imem[k]     = prog_mem[k];
      dut.r_imem[k] = prog_mem[k];
    end
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_pc = PC0;
    #(hold_ns);
    @(negedge clk);
    check("rst_pc", pc, PC0);
    check("rst_inst", inst, prog_mem[0]);
    check("rst_r1", dut.u_regfile.r_regs[1], 32'd0);
    reset = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1 push_exp();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic mid_reset();
    int bad;
    reset = 1'b0;
    #1;
    check("async_rst_pc", pc, PC0);
    bad = 1;
    for (int r = 31; r >= 1; r--) if (dut.u_regfile.r_regs[r] !== 32'd0) bad = r;
    check("async_rst_regs", dut.u_regfile.r_regs[bad], 32'd0);
    bad = 0;
    for (int k = 1023; k >= 0; k--) if (dut.r_dmem[k] !== m_dmem[k]) bad = k;
    check("dmem_kept", dut.r_dmem[bad], m_dmem[bad]);
  endtask

  function automatic logic [31:0] rand_inst();
    int          rs  = int'($urandom_range(0, 7));
    int          rt  = int'($urandom_range(0, 7));
    int          rd  = int'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    logic [15:0] bim = 16'(int'($urandom_range(0, 8)) - 4);
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return rt_i(rs, rt, rd, int'($urandom_range(0, 31)), FNS[$urandom_range(0, 15)]);
      4, 5, 6:    return it_i(IOPS[$urandom_range(0, 7)], rs, rt, imm);
      7:          return it_i(($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2b, rs, rt, imm);
      8:          return it_i(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, rs, rt, bim);
      9:          return jt_i(($urandom_range(0, 1) == 0) ? 6'h02 : 6'h03,
                              26'((PC0 >> 2) + $urandom_range(0, 61)));
      10:         return rt_i(31, 0, 0, 0, 6'h08);
      default:    return ($urandom_range(0, 1) == 0) ? {6'h3f, 26'($urandom)} : rt_i(rs, rt, rd, 0, 6'h01);
    endcase
  endfunction

  initial begin : p_main
    for (int k = 0; k < 1024; k++) begin
      m_dmem[k]     = '0;
      dut.r_dmem[k] = '0;
      prog_mem[k]   = '0;
    end

    // Directed program exercising ALU, memory, branches, jumps and $0.
    prog_mem[0]    = it_i(6'h0d, 0, 1, 16'd5);          // ori  $1,$0,5
    prog_mem[1]    = it_i(6'h08, 0, 2, 16'hfffd);       // addi $2,$0,-3
    prog_mem[2]    = rt_i(1, 2, 3, 0, 6'h20);           // add  $3,$1,$2
    prog_mem[3]    = rt_i(1, 2, 4, 0, 6'h2b);           // sltu $4,$1,$2
    prog_mem[4]    = it_i(6'h04, 0, 0, 16'd2);          // beq  $0,$0,2 -> 0x1C
    prog_mem[5]    = it_i(6'h08, 0, 8, 16'd1);          // skipped
    prog_mem[6]    = it_i(6'h08, 0, 8, 16'd2);          // skipped
    prog_mem[7]    = rt_i(0, 2, 5, 1, 6'h03);           // sra  $5,$2,1
    prog_mem[8]    = jt_i(6'h03, 26'h0100040);          // jal  0x00400100
    prog_mem[9]    = it_i(6'h0f, 0, 6, 16'h1001);       // lui  $6,0x1001
    prog_mem[10]   = it_i(6'h2b, 6, 3, 16'd8);          // sw   $3,8($6)
    prog_mem[11]   = it_i(6'h23, 6, 7, 16'd8);          // lw   $7,8($6)
    prog_mem[12]   = it_i(6'h05, 1, 1, 16'd5);          // bne  $1,$1 (not taken)
    prog_mem[13]   = it_i(6'h08, 0, 0, 16'd7);          // addi $0,$0,7
    prog_mem[14]   = it_i(6'h0f, 0, 9, 16'h7fff);       // lui  $9,0x7fff
    prog_mem[15]   = it_i(6'h0d, 9, 9, 16'hffff);       // ori  $9,$9,0xffff
    prog_mem[16]   = it_i(6'h08, 0, 10, 16'd1);         // addi $10,$0,1
    prog_mem[17]   = rt_i(9, 10, 11, 0, 6'h20);         // add  $11,$9,$10
    prog_mem[18]   = jt_i(6'h02, 26'h0100012);          // j    self
    prog_mem[9'h40] = rt_i(31, 0, 0, 0, 6'h08);         // jr   $31

    start_prog(50);
    run_cycles(22);
    check("r3_add", dut.u_regfile.r_regs[3], 32'd2);
    check("r4_sltu", dut.u_regfile.r_regs[4], 32'd1);
    check("r5_sra", dut.u_regfile.r_regs[5], 32'hffff_fffe);
    check("r7_lw", dut.u_regfile.r_regs[7], 32'd2);
    check("dmem2", dut.r_dmem[2], 32'd2);
    check("r31_jal", dut.u_regfile.r_regs[31], 32'h0040_0024);
    check("r0_zero", dut.u_regfile.r_regs[0], 32'd0);
    check("r8_skipped", dut.u_regfile.r_regs[8], 32'd0);
`ifdef OVERFLOW_TRAP_EN
    check("r11_ovf", dut.u_regfile.r_regs[11], 32'd0);
`else
    check("r11_ovf", dut.u_regfile.r_regs[11], 32'h8000_0000);
`endif
    check("pc_loop", pc, 32'h0040_0048);
    mid_reset();

    // Random programs: register seeding prologue followed by random code.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 1024; k++) prog_mem[k] = '0;
      for (int r = 1; r < 8; r++) begin
        prog_mem[r - 1] = it_i(6'h0f, 0, r, 16'($urandom));
        prog_mem[r + 6] = it_i(6'h0d, r, r, 16'($urandom));
      end
      prog_mem[14] = it_i(6'h0f, 0, 6, 16'h1001);
      for (int k = 15; k < 62; k++) prog_mem[k] = rand_inst();
      start_prog(0);
      run_cycles(150);
      mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : p_watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
